pcie_egress_arbiter: RTL and testbench

Shares the single PCIe egress TLP engine among three requesters: the configuration/status writer (register-map push plus interrupt), the host-bound data writer (memory write from write buffers A/B), and the read-request issuer (memory read to read buffers A/B). It sits between those sequencers and the egress state machine. It owns `o_egress_enable`, latches and muxes the TLP header, and selects the egress FIFO source. It also gates on flow-control credit and recovers from a hung egress engine with a watchdog.

---
 rtl/pcie_egress_arb_pkg.sv | 26 ++
 rtl/pcie_egress_pick.sv | 38 +++
 rtl/pcie_egress_arbiter.sv | 170 +++++++++++++++++
 tb/tb_pcie_egress_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_egress_arb_pkg.sv
// ---------------------------------------------------------------------------
// pcie_egress_arb_pkg
// Shared definitions for the PCIe egress arbiter: requester indices,
// requester count, header field widths and the arbiter state encoding.
// ---------------------------------------------------------------------------
package pcie_egress_arb_pkg;

   localparam int REQ_CFG   = 0;   // configuration/status writer
   localparam int REQ_WR    = 1;   // host-bound data writer
   localparam int REQ_RD    = 2;   // read-request issuer
   localparam int REQ_COUNT = 3;

   localparam int CMD_W   = 8;
   localparam int FLAGS_W = 14;
   localparam int ADDR_W  = 32;
   localparam int RID_W   = 16;
   localparam int TAG_W   = 8;

   // 4-bit encodings shared with the other egress controllers
   typedef enum logic [3:0] {
      ST_IDLE = 4'h0,
      ST_SEND = 4'h1,
      ST_DONE = 4'h2
   } arb_state_t;

endpackage

// File: rtl/pcie_egress_pick.sv
// ---------------------------------------------------------------------------
// pcie_egress_pick
// Combinational winner select for the egress arbiter.
//   req[2:0]         : pending requests (0 = cfg, 1 = data write, 2 = read)
//   cfg_streak_full  : cfg has used its burst allowance
//   last_data[1:0]   : index of the last data winner (1 or 2)
//   winner[2:0]      : one-hot winner, all zero when nothing is requested
// ---------------------------------------------------------------------------
module pcie_egress_pick
   import pcie_egress_arb_pkg::*;
(
   input  logic [REQ_COUNT-1:0] req,
   input  logic                 cfg_streak_full,
   input  logic [1:0]           last_data,
   output logic [REQ_COUNT-1:0] winner
);

   logic w_data_pend;

   assign w_data_pend = req[REQ_WR] | req[REQ_RD];

   always_comb begin
      winner = '0;
      // cfg yields only once its burst is spent and a data requester waits
      if (req[REQ_CFG] && !(cfg_streak_full && w_data_pend)) begin
         winner[REQ_CFG] = 1'b1;
      end else if (req[REQ_WR] && req[REQ_RD]) begin
         // both data requesters: prefer the one that did not win last
         if (last_data == 2'(REQ_RD)) winner[REQ_WR] = 1'b1;
         else                         winner[REQ_RD] = 1'b1;
      end else if (req[REQ_WR]) begin
         winner[REQ_WR] = 1'b1;
      end else if (req[REQ_RD]) begin
         winner[REQ_RD] = 1'b1;
      end
   end

endmodule

// File: rtl/pcie_egress_arbiter.sv
// ---------------------------------------------------------------------------
// pcie_egress_arbiter
// Shares the PCIe egress TLP engine among the cfg writer, data writer and
// read-request issuer. Latches the winner's header, drives the egress
// enable and FIFO source select, gates on flow-control credit and aborts a
// hung transfer with a watchdog.
// Ports:
//   clk, rst (sync, active-high), i_cmd_rst_stb (in-band reset pulse)
//   i_pcie_fc_ready          : credit available, sampled in IDLE only
//   i_req / o_gnt            : per-requester request / one-hot grant
//   o_done / o_err           : completion / abort pulses to the winner
//   i_req_tlp_* / i_req_tag  : packed per-requester header inputs
//   o_egress_enable          : high for the whole SEND phase
//   i_egress_finished        : engine completed the TLP
//   o_egress_tlp_* / o_egress_tag : latched header of the winner
//   o_egress_cntrl_fifo_select    : 1 = control FIFO (cfg winner)
//   o_timeout_count          : saturating count of watchdog aborts
// ---------------------------------------------------------------------------
module pcie_egress_arbiter
   import pcie_egress_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CFG_BURST_MAX  = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_cmd_rst_stb,
   input  logic                           i_pcie_fc_ready,
   input  logic [REQ_COUNT-1:0]           i_req,
   output logic [REQ_COUNT-1:0]           o_gnt,
   output logic [REQ_COUNT-1:0]           o_done,
   output logic [REQ_COUNT-1:0]           o_err,
   input  logic [REQ_COUNT*CMD_W-1:0]     i_req_tlp_command,
   input  logic [REQ_COUNT*FLAGS_W-1:0]   i_req_tlp_flags,
   input  logic [REQ_COUNT*ADDR_W-1:0]    i_req_tlp_address,
   input  logic [REQ_COUNT*RID_W-1:0]     i_req_tlp_requester_id,
   input  logic [REQ_COUNT*TAG_W-1:0]     i_req_tag,
   output logic                           o_egress_enable,
   input  logic                           i_egress_finished,
   output logic [CMD_W-1:0]               o_egress_tlp_command,
   output logic [FLAGS_W-1:0]             o_egress_tlp_flags,
   output logic [ADDR_W-1:0]              o_egress_tlp_address,
   output logic [RID_W-1:0]               o_egress_tlp_requester_id,
   output logic [TAG_W-1:0]               o_egress_tag,
   output logic                           o_egress_cntrl_fifo_select,
   output logic [7:0]                     o_timeout_count
);

   localparam int STREAK_W = $clog2(CFG_BURST_MAX + 1);

   arb_state_t             r_state, w_state_next;
   logic [REQ_COUNT-1:0]   r_winner, w_winner;
   logic [1:0]             r_last_data;
   logic [STREAK_W-1:0]    r_cfg_streak;
   logic [15:0]            r_wdog;
   logic [16:0]            w_wdog_inc;
   logic                   r_abort;
   logic                   w_rst, w_start, w_timeout, w_streak_full;
   logic [CMD_W-1:0]       w_hdr_cmd;
   logic [FLAGS_W-1:0]     w_hdr_flags;
   logic [ADDR_W-1:0]      w_hdr_addr;
   logic [RID_W-1:0]       w_hdr_rid;
   logic [TAG_W-1:0]       w_hdr_tag;

   assign w_rst         = rst | i_cmd_rst_stb;
   assign w_start       = i_pcie_fc_ready & (|i_req);
   assign w_wdog_inc    = {1'b0, r_wdog} + 17'd1;
   assign w_timeout     = (w_wdog_inc == 17'(TIMEOUT_CYCLES));
   assign w_streak_full = (r_cfg_streak == STREAK_W'(CFG_BURST_MAX));

   pcie_egress_pick u_pick (
      .req             (i_req),
      .cfg_streak_full (w_streak_full),
      .last_data       (r_last_data),
      .winner          (w_winner)
   );

   // Header mux from the one-hot winner
   always_comb begin
      w_hdr_cmd   = '0;
      w_hdr_flags = '0;
      w_hdr_addr  = '0;
      w_hdr_rid   = '0;
      w_hdr_tag   = '0;
      for (int k = 0; k < REQ_COUNT; k++) begin
         if (w_winner[k]) begin
            w_hdr_cmd   = i_req_tlp_command[CMD_W*k +: CMD_W];
            w_hdr_flags = i_req_tlp_flags[FLAGS_W*k +: FLAGS_W];
            w_hdr_addr  = i_req_tlp_address[ADDR_W*k +: ADDR_W];
            w_hdr_rid   = i_req_tlp_requester_id[RID_W*k +: RID_W];
            w_hdr_tag   = i_req_tag[TAG_W*k +: TAG_W];
         end
      end
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (w_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   // FSM: next state. A finish in the same cycle as a timeout wins (no abort).
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_start) w_state_next = ST_SEND;
         ST_SEND: if (i_egress_finished || w_timeout) w_state_next = ST_DONE;
         ST_DONE: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // FSM: outputs, decoded from registered state only
   always_comb begin
      o_egress_enable = (r_state == ST_SEND);
      o_gnt  = (r_state == ST_SEND) ? r_winner : '0;
      o_done = (r_state == ST_DONE) ? r_winner : '0;
      o_err  = (r_state == ST_DONE && r_abort) ? r_winner : '0;
   end

   // Datapath: header latch, arbitration history, watchdog, abort counter
   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_winner                   <= '0;
         r_last_data                <= 2'(REQ_RD);
         r_cfg_streak               <= '0;
         r_wdog                     <= '0;
         r_abort                    <= 1'b0;
         o_timeout_count            <= '0;
         o_egress_cntrl_fifo_select <= 1'b0;
         o_egress_tlp_command       <= '0;
         o_egress_tlp_flags         <= '0;
         o_egress_tlp_address       <= '0;
         o_egress_tlp_requester_id  <= '0;
         o_egress_tag               <= '0;
      end else begin
         if (r_state == ST_IDLE && w_start) begin
            r_winner                   <= w_winner;
            o_egress_cntrl_fifo_select <= w_winner[REQ_CFG];
            o_egress_tlp_command       <= w_hdr_cmd;
            o_egress_tlp_flags         <= w_hdr_flags;
            o_egress_tlp_address       <= w_hdr_addr;
            o_egress_tlp_requester_id  <= w_hdr_rid;
            o_egress_tag               <= w_hdr_tag;
            if (w_winner[REQ_CFG]) begin
               // streak only grows while cfg is holding off a data requester
               if (|i_req[REQ_RD:REQ_WR]) begin
                  if (!w_streak_full) r_cfg_streak <= r_cfg_streak + 1'b1;
               end else begin
                  r_cfg_streak <= '0;
               end
            end else begin
               r_cfg_streak <= '0;
               r_last_data  <= w_winner[REQ_RD] ? 2'(REQ_RD) : 2'(REQ_WR);
            end
         end

         if (r_state == ST_SEND) r_wdog <= w_wdog_inc[15:0];
         else                    r_wdog <= '0;

         if (r_state == ST_SEND && w_timeout && !i_egress_finished) begin
            r_abort <= 1'b1;
            if (o_timeout_count != 8'hFF) o_timeout_count <= o_timeout_count + 8'd1;
         end else if (r_state == ST_DONE) begin
            r_abort <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pcie_egress_arbiter.sv
module tb_pcie_egress_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_cmd_rst_stb;
   logic        i_pcie_fc_ready;
   logic [2:0]  i_req;
   logic [2:0]  o_gnt, o_done, o_err;
   logic [23:0] i_req_tlp_command;
   logic [41:0] i_req_tlp_flags;
   logic [95:0] i_req_tlp_address;
   logic [47:0] i_req_tlp_requester_id;
   logic [23:0] i_req_tag;
   logic        o_egress_enable;
   logic        i_egress_finished;
   logic [7:0]  o_egress_tlp_command;
   logic [13:0] o_egress_tlp_flags;
   logic [31:0] o_egress_tlp_address;
   logic [15:0] o_egress_tlp_requester_id;
   logic [7:0]  o_egress_tag;
   logic        o_egress_cntrl_fifo_select;
   logic [7:0]  o_timeout_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pcie_egress_arbiter #(.TIMEOUT_CYCLES(16), .CFG_BURST_MAX(2)) dut (
      .clk                        (clk),
      .rst                        (rst),
      .i_cmd_rst_stb              (i_cmd_rst_stb),
      .i_pcie_fc_ready            (i_pcie_fc_ready),
      .i_req                      (i_req),
      .o_gnt                      (o_gnt),
      .o_done                     (o_done),
      .o_err                      (o_err),
      .i_req_tlp_command          (i_req_tlp_command),
      .i_req_tlp_flags            (i_req_tlp_flags),
      .i_req_tlp_address          (i_req_tlp_address),
      .i_req_tlp_requester_id     (i_req_tlp_requester_id),
      .i_req_tag                  (i_req_tag),
      .o_egress_enable            (o_egress_enable),
      .i_egress_finished          (i_egress_finished),
      .o_egress_tlp_command       (o_egress_tlp_command),
      .o_egress_tlp_flags         (o_egress_tlp_flags),
      .o_egress_tlp_address       (o_egress_tlp_address),
      .o_egress_tlp_requester_id  (o_egress_tlp_requester_id),
      .o_egress_tag               (o_egress_tag),
      .o_egress_cntrl_fifo_select (o_egress_cntrl_fifo_select),
      .o_timeout_count            (o_timeout_count)
   );

   // advance one clock; outputs are sampled and inputs driven 1 ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      i_req = 3'b000;
      i_egress_finished = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (o_gnt !== 3'b000 || o_egress_enable !== 1'b0 || o_done !== 3'b000 || o_err !== 3'b000) begin
         errors++;
         $display("FAIL reset_ctrl: gnt=%b en=%b done=%b err=%b, required all 0", o_gnt, o_egress_enable, o_done, o_err);
      end
      checks++;
      if (o_timeout_count !== 8'd0 || o_egress_cntrl_fifo_select !== 1'b0 || o_egress_tlp_command !== 8'h00) begin
         errors++;
         $display("FAIL reset_regs: tmo=%0d sel=%b cmd=%h, required 0/0/00", o_timeout_count, o_egress_cntrl_fifo_select, o_egress_tlp_command);
      end
      $display("reset: gnt=%b en=%b tmo=%0d", o_gnt, o_egress_enable, o_timeout_count);
   endtask

   task automatic test_cfg_single();
      logic en_ok;
      do_reset();
      i_pcie_fc_ready = 1'b1;
      i_req = 3'b001;
      tick();
      i_req = 3'b000;
      checks++;
      if (o_gnt !== 3'b001 || o_egress_enable !== 1'b1 || o_egress_cntrl_fifo_select !== 1'b1) begin
         errors++;
         $display("FAIL cfg_grant: gnt=%b en=%b sel=%b, required 001/1/1", o_gnt, o_egress_enable, o_egress_cntrl_fifo_select);
      end
      checks++;
      if (o_egress_tlp_command !== 8'hA0 || o_egress_tlp_flags !== 14'h0AAA || o_egress_tlp_address !== 32'h1000_0010
          || o_egress_tlp_requester_id !== 16'h0100 || o_egress_tag !== 8'h11) begin
         errors++;
         $display("FAIL cfg_header: cmd=%h flags=%h addr=%h rid=%h tag=%h, required A0/0aaa/10000010/0100/11",
                  o_egress_tlp_command, o_egress_tlp_flags, o_egress_tlp_address, o_egress_tlp_requester_id, o_egress_tag);
      end
      // header must stay frozen even if the requester changes its inputs
      i_req_tlp_command[7:0] = 8'h5A;
      en_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (o_egress_enable !== 1'b1 || o_done !== 3'b000) en_ok = 1'b0;
      end
      checks++;
      if (en_ok !== 1'b1 || o_egress_tlp_command !== 8'hA0) begin
         errors++;
         $display("FAIL cfg_hold: enable_held=%b cmd=%h, required 1/A0", en_ok, o_egress_tlp_command);
      end
      i_req_tlp_command[7:0] = 8'hA0;
      i_egress_finished = 1'b1;
      tick();
      i_egress_finished = 1'b0;
      checks++;
      if (o_done !== 3'b001 || o_err !== 3'b000 || o_egress_enable !== 1'b0 || o_gnt !== 3'b000) begin
         errors++;
         $display("FAIL cfg_done: done=%b err=%b en=%b gnt=%b, required 001/000/0/000", o_done, o_err, o_egress_enable, o_gnt);
      end
      tick();
      checks++;
      if (o_done !== 3'b000) begin
         errors++;
         $display("FAIL cfg_done_pulse: done=%b, required 000", o_done);
      end
      $display("cfg_single: done transaction finished");
   endtask

   // run a sequence of grants with requests held, checking each grant in order
   task automatic run_order(input string name, input logic [2:0] req, input int n, input logic [2:0] exp [6]);
      logic [7:0] exp_cmd;
      do_reset();
      i_pcie_fc_ready = 1'b1;
      i_req = req;
      for (int t = 0; t < n; t++) begin
         for (int c = 0; c < 10 && o_gnt === 3'b000; c++) tick();
         exp_cmd = exp[t][0] ? 8'hA0 : (exp[t][1] ? 8'hB1 : 8'hC2);
         checks++;
         if (o_gnt !== exp[t] || o_egress_cntrl_fifo_select !== exp[t][0] || o_egress_tlp_command !== exp_cmd) begin
            errors++;
            $display("FAIL %s_grant%0d: gnt=%b sel=%b cmd=%h, required %b/%b/%h", name, t,
                     o_gnt, o_egress_cntrl_fifo_select, o_egress_tlp_command, exp[t], exp[t][0], exp_cmd);
         end
         $display("%s: transaction %0d gnt=%b", name, t, o_gnt);
         i_egress_finished = 1'b1;
         tick();
         i_egress_finished = 1'b0;
      end
      i_req = 3'b000;
      tick();
      tick();
   endtask

   task automatic test_data_rr();
      logic [2:0] exp [6];
      exp = '{3'b010, 3'b100, 3'b010, 3'b100, 3'b000, 3'b000};
      run_order("data_rr", 3'b110, 4, exp);
   endtask

   task automatic test_cfg_burst();
      logic [2:0] exp [6];
      exp = '{3'b001, 3'b001, 3'b010, 3'b001, 3'b001, 3'b100};
      run_order("cfg_burst", 3'b111, 6, exp);
   endtask

   task automatic test_fc_gate();
      logic idle_ok;
      do_reset();
      i_pcie_fc_ready = 1'b0;
      i_req = 3'b010;
      idle_ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         // a stray finish while idle must be ignored
         i_egress_finished = (i == 7);
         tick();
         if (o_gnt !== 3'b000 || o_egress_enable !== 1'b0 || o_done !== 3'b000) idle_ok = 1'b0;
      end
      i_egress_finished = 1'b0;
      checks++;
      if (idle_ok !== 1'b1) begin
         errors++;
         $display("FAIL fc_block: grant or enable seen without credit, required none");
      end
      i_pcie_fc_ready = 1'b1;
      tick();
      i_req = 3'b000;
      checks++;
      if (o_gnt !== 3'b010 || o_egress_enable !== 1'b1) begin
         errors++;
         $display("FAIL fc_grant: gnt=%b en=%b, required 010/1", o_gnt, o_egress_enable);
      end
      $display("fc_gate: gnt=%b after credit", o_gnt);
      i_egress_finished = 1'b1;
      tick();
      i_egress_finished = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      int n;
      do_reset();
      i_pcie_fc_ready = 1'b1;
      i_req = 3'b010;
      tick();
      i_req = 3'b000;
      n = (o_egress_enable === 1'b1) ? 1 : 0;
      for (int c = 0; c < 100 && o_egress_enable === 1'b1; c++) begin
         tick();
         if (o_egress_enable === 1'b1) n++;
      end
      checks++;
      if (n != 16) begin
         errors++;
         $display("FAIL tmo_len: enable high %0d cycles, required 16", n);
      end
      checks++;
      if (o_done !== 3'b010 || o_err !== 3'b010 || o_timeout_count !== 8'd1) begin
         errors++;
         $display("FAIL tmo_abort: done=%b err=%b tmo=%0d, required 010/010/1", o_done, o_err, o_timeout_count);
      end
      tick();
      checks++;
      if (o_err !== 3'b000 || o_done !== 3'b000 || o_timeout_count !== 8'd1) begin
         errors++;
         $display("FAIL tmo_after: done=%b err=%b tmo=%0d, required 000/000/1", o_done, o_err, o_timeout_count);
      end
      $display("timeout: enable cycles=%0d tmo=%0d", n, o_timeout_count);
   endtask

   task automatic test_cmd_rst();
      do_reset();
      i_pcie_fc_ready = 1'b1;
      i_req = 3'b001;
      tick();
      i_req = 3'b000;
      checks++;
      if (o_gnt !== 3'b001) begin
         errors++;
         $display("FAIL crst_grant: gnt=%b, required 001", o_gnt);
      end
      tick();
      tick();
      i_cmd_rst_stb = 1'b1;
      tick();
      i_cmd_rst_stb = 1'b0;
      checks++;
      if (o_gnt !== 3'b000 || o_egress_enable !== 1'b0 || o_done !== 3'b000 || o_err !== 3'b000
          || o_egress_cntrl_fifo_select !== 1'b0 || o_egress_tlp_command !== 8'h00) begin
         errors++;
         $display("FAIL crst_clear: gnt=%b en=%b done=%b err=%b sel=%b cmd=%h, required all 0",
                  o_gnt, o_egress_enable, o_done, o_err, o_egress_cntrl_fifo_select, o_egress_tlp_command);
      end
      tick();
      checks++;
      if (o_done !== 3'b000 || o_egress_enable !== 1'b0) begin
         errors++;
         $display("FAIL crst_nodone: done=%b en=%b, required 000/0", o_done, o_egress_enable);
      end
      i_req = 3'b100;
      tick();
      i_req = 3'b000;
      checks++;
      if (o_gnt !== 3'b100 || o_egress_tlp_command !== 8'hC2) begin
         errors++;
         $display("FAIL crst_regrant: gnt=%b cmd=%h, required 100/C2", o_gnt, o_egress_tlp_command);
      end
      i_egress_finished = 1'b1;
      tick();
      i_egress_finished = 1'b0;
      checks++;
      if (o_done !== 3'b100) begin
         errors++;
         $display("FAIL crst_done: done=%b, required 100", o_done);
      end
      tick();
      $display("cmd_rst: recovered, regrant done");
   endtask

   initial begin
      rst = 1'b1;
      i_cmd_rst_stb = 1'b0;
      i_pcie_fc_ready = 1'b0;
      i_req = 3'b000;
      i_egress_finished = 1'b0;
      i_req_tlp_command      = {8'hC2, 8'hB1, 8'hA0};
      i_req_tlp_flags        = {14'h2222, 14'h1111, 14'h0AAA};
      i_req_tlp_address      = {32'h3000_0030, 32'h2000_0020, 32'h1000_0010};
      i_req_tlp_requester_id = {16'h0300, 16'h0200, 16'h0100};
      i_req_tag              = {8'h33, 8'h22, 8'h11};
      tick();
      test_reset();
      test_cfg_single();
      test_data_rr();
      test_cfg_burst();
      test_fc_gate();
      test_timeout();
      test_cmd_rst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
